sonic_eth_10g_rx_st_arbiter: RTL and testbench

- Packet-aware 2:1 round-robin arbiter that shares one 72-bit Avalon-ST RX sink (64b data + 8b control per beat) between two 10G MAC RX streams.
- Grants whole packets (SOP to EOP) with a registered output stage.
- Aborts a granted packet whose source stalls too long by injecting an error-terminated EOP beat.
- Sits between the MAC RX timing adapters and the shared downstream RX consumer (DMA/packet buffer).

---
 rtl/sonic_eth_10g_rx_st_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sonic_eth_10g_rx_st_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonic_eth_10g_rx_st_arbiter.sv
// Packet-aware 2:1 round-robin arbiter sharing one Avalon-ST RX sink between two 10G MAC RX streams.
// Latency: accepted beat appears on out_* one cycle later; SOP request to first out_valid is 2 cycles.
// Backpressure: inputs are ready only while the output register is free; stalled packets are aborted with an error EOP.
module sonic_eth_10g_rx_st_arbiter #(
    parameter int DATA_W  = 72,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    input  logic              in0_sop,
    input  logic              in0_eop,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    input  logic              in1_sop,
    input  logic              in1_eop,
    output logic              in1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_error,
    input  logic              out_ready,
    output logic [1:0]        grant,
    output logic              abort_pulse,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam int          SUM_W     = CNT_W + 1;
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        grant_nxt;
    logic              rr_ptr;
    logic              rr_nxt;
    logic [15:0]       stall_cnt;
    logic [15:0]       stall_nxt;
    logic              free;
    logic              sel;
    logic              sel_valid;
    logic              sel_sop;
    logic              sel_eop;
    logic [DATA_W-1:0] sel_data;
    logic              req0;
    logic              req1;
    logic              drop0;
    logic              drop1;
    logic              load_beat;
    logic              load_abort;
    logic              eop_done;
    logic [SUM_W-1:0]  drop_sum;

    assign free      = !out_valid || out_ready;
    assign sel       = grant[1];
    assign sel_valid = sel ? in1_valid : in0_valid;
    assign sel_sop   = sel ? in1_sop   : in0_sop;
    assign sel_eop   = sel ? in1_eop   : in0_eop;
    assign sel_data  = sel ? in1_data  : in0_data;
    assign req0      = in0_valid && in0_sop;
    assign req1      = in1_valid && in1_sop;
    assign drop_sum  = {1'b0, drop_cnt} + SUM_W'(drop0) + SUM_W'(drop1);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, handshake and next-state decisions
    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        rr_nxt     = rr_ptr;
        stall_nxt  = stall_cnt;
        in0_ready  = 1'b0;
        in1_ready  = 1'b0;
        load_beat  = 1'b0;
        load_abort = 1'b0;
        eop_done   = 1'b0;
        drop0      = 1'b0;
        drop1      = 1'b0;
        case (state)
            IDLE: begin
                // SOP beats wait for the grant; anything else is a leftover tail and is discarded
                drop0     = in0_valid && !in0_sop;
                drop1     = in1_valid && !in1_sop;
                in0_ready = drop0;
                in1_ready = drop1;
                stall_nxt = '0;
                if (req0 && req1) begin
                    grant_nxt = rr_ptr ? 2'b01 : 2'b10;
                end else if (req0) begin
                    grant_nxt = 2'b01;
                end else if (req1) begin
                    grant_nxt = 2'b10;
                end
                if (req0 || req1) begin
                    state_nxt = XFER;
                end
            end
            XFER: begin
                in0_ready = grant[0] && free;
                in1_ready = grant[1] && free;
                if (sel_valid && free) begin
                    load_beat = 1'b1;
                    stall_nxt = '0;
                    if (sel_eop) begin
                        eop_done  = 1'b1;
                        rr_nxt    = sel;
                        grant_nxt = 2'b00;
                        state_nxt = IDLE;
                    end
                end else if (!sel_valid) begin
                    // Only a silent source counts as stalled; downstream backpressure does not
                    stall_nxt = stall_cnt + 16'd1;
                    if (stall_nxt >= TIMEOUT_C) begin
                        state_nxt = ABORT;
                    end
                end
            end
            ABORT: begin
                if (free) begin
                    load_abort = 1'b1;
                    rr_nxt     = sel;
                    grant_nxt  = 2'b00;
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 2'b00;
            end
        endcase
    end

    // Grant, round-robin pointer and stall counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= 2'b00;
            rr_ptr    <= 1'b1;
            stall_cnt <= '0;
        end else begin
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            stall_cnt <= stall_nxt;
        end
    end

    // Output register: loads a forwarded beat or the abort beat when free, otherwise holds
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_error   <= 1'b0;
            abort_pulse <= 1'b0;
        end else begin
            abort_pulse <= load_abort;
            if (free) begin
                out_valid <= load_beat || load_abort;
                out_data  <= load_beat ? sel_data : '0;
                out_sop   <= load_beat && sel_sop;
                out_eop   <= (load_beat && sel_eop) || load_abort;
                out_error <= load_abort;
            end
        end
    end

    // Statistics: per-input packet counters wrap, drop counter saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            drop_cnt <= '0;
        end else begin
            if (eop_done && !sel) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (eop_done && sel) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_sonic_eth_10g_rx_st_arbiter.sv
`timescale 1ns/1ps
module tb_sonic_eth_10g_rx_st_arbiter;

    localparam int DATA_W  = 72;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int GLOG_N  = 8192;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in0_data = '0;
    logic              in0_valid = 1'b0;
    logic              in0_sop = 1'b0;
    logic              in0_eop = 1'b0;
    logic              in0_ready;
    logic [DATA_W-1:0] in1_data = '0;
    logic              in1_valid = 1'b0;
    logic              in1_sop = 1'b0;
    logic              in1_eop = 1'b0;
    logic              in1_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_sop;
    logic              out_eop;
    logic              out_error;
    logic              out_ready = 1'b1;
    logic [1:0]        grant;
    logic              abort_pulse;
    logic [CNT_W-1:0]  pkt_cnt0;
    logic [CNT_W-1:0]  pkt_cnt1;
    logic [CNT_W-1:0]  drop_cnt;

    always #5 clk = ~clk;

    sonic_eth_10g_rx_st_arbiter #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in0_data    (in0_data),
        .in0_valid   (in0_valid),
        .in0_sop     (in0_sop),
        .in0_eop     (in0_eop),
        .in0_ready   (in0_ready),
        .in1_data    (in1_data),
        .in1_valid   (in1_valid),
        .in1_sop     (in1_sop),
        .in1_eop     (in1_eop),
        .in1_ready   (in1_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .out_error   (out_error),
        .out_ready   (out_ready),
        .grant       (grant),
        .abort_pulse (abort_pulse),
        .pkt_cnt0    (pkt_cnt0),
        .pkt_cnt1    (pkt_cnt1),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        int                gap;
    } src_beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
        logic              err;
    } out_beat_t;

    src_beat_t q0[$];
    src_beat_t q1[$];
    out_beat_t exp_q[$];
    int        sopq[$];
    int        eopq[$];
    logic [1:0] glog [0:GLOG_N-1];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   rst_req = 1'b1;
    bit   take0 = 1'b0;
    bit   take1 = 1'b0;
    int   rdy_mode = 0;
    int   rdy_ph = 0;
    bit   bp_chk = 1'b0;
    bit   prev_stall = 1'b0;
    logic [75:0] prev_out = '0;
    int   hold_viol = 0;
    int   rdy_viol = 0;
    int   n_abort = 0;
    int   last_take0_cyc = 0;
    int   abort_gap = -1;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, observe outputs and handshakes just after
    task automatic step();
        src_beat_t b;
        out_beat_t ob;
        out_beat_t eb;
        @(negedge clk);
        reset = rst_req;
        if (take0 && q0.size() > 0) b = q0.pop_front();
        if (take1 && q1.size() > 0) b = q1.pop_front();
        in0_valid = 1'b0;
        if (q0.size() > 0) begin
            b = q0[0];
            if (b.gap > 0) begin
                b.gap = b.gap - 1;
                q0[0] = b;
            end else begin
                in0_valid = 1'b1;
                in0_data  = b.data;
                in0_sop   = b.sop;
                in0_eop   = b.eop;
            end
        end
        in1_valid = 1'b0;
        if (q1.size() > 0) begin
            b = q1[0];
            if (b.gap > 0) begin
                b.gap = b.gap - 1;
                q1[0] = b;
            end else begin
                in1_valid = 1'b1;
                in1_data  = b.data;
                in1_sop   = b.sop;
                in1_eop   = b.eop;
            end
        end
        if (rdy_mode == 0) begin
            out_ready = 1'b1;
        end else begin
            out_ready = (rdy_ph == 0);
            rdy_ph = (rdy_ph + 1) % 3;
        end
        #1;
        take0 = in0_valid && in0_ready;
        take1 = in1_valid && in1_ready;
        if (take0) last_take0_cyc = cyc;
        if (cyc < GLOG_N) glog[cyc] = grant;
        if (abort_pulse) n_abort++;
        if (bp_chk) begin
            if (out_valid && !out_ready && in1_ready) rdy_viol++;
            if (prev_stall && ({out_valid, out_data, out_sop, out_eop, out_error} != prev_out)) hold_viol++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, out_data, out_sop, out_eop, out_error};
        if (out_valid && out_ready) begin
            ob = '{out_data, out_sop, out_eop, out_error};
            chk("sb_pending", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                eb = exp_q.pop_front();
                chk("sb_beat", 128'(ob), 128'(eb));
            end
            if (out_sop) sopq.push_back(cyc);
            if (out_eop) eopq.push_back(cyc);
            if (out_error) abort_gap = cyc - last_take0_cyc;
        end
        cyc++;
    endtask

    task automatic send(input int port, input int nb, input logic [7:0] tag);
        src_beat_t b;
        out_beat_t e;
        for (int i = 0; i < nb; i++) begin
            b.data = {tag, 8'(i), 32'($urandom()), 24'($urandom())};
            b.sop  = (i == 0);
            b.eop  = (i == nb - 1);
            b.gap  = 0;
            if (port == 0) q0.push_back(b);
            else           q1.push_back(b);
            e = '{b.data, b.sop, b.eop, 1'b0};
            exp_q.push_back(e);
        end
    endtask

    task automatic push_raw(input int port, input logic sop, input logic eop, input int gap);
        src_beat_t b;
        b.data = {8'hEE, 32'($urandom()), 32'($urandom())};
        b.sop  = sop;
        b.eop  = eop;
        b.gap  = gap;
        if (port == 0) q0.push_back(b);
        else           q1.push_back(b);
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        chk("drain_done", 128'(q0.size() + q1.size() + exp_q.size()), 128'(0));
        repeat (3) step();
    endtask

    task automatic clear_bench();
        q0.delete();
        q1.delete();
        exp_q.delete();
        take0 = 1'b0;
        take1 = 1'b0;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
        clear_bench();
        step();
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_out_valid"}, 128'(out_valid), 128'(0));
        chk({pfx, "_out_flags"}, 128'({out_sop, out_eop, out_error}), 128'(0));
        chk({pfx, "_grant"}, 128'(grant), 128'(0));
        chk({pfx, "_pkt_cnt0"}, 128'(pkt_cnt0), 128'(0));
        chk({pfx, "_pkt_cnt1"}, 128'(pkt_cnt1), 128'(0));
        chk({pfx, "_drop_cnt"}, 128'(drop_cnt), 128'(0));
    endtask

    initial begin
        int c0;
        logic [CNT_W-1:0] pc0;

        // Reset state
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        step();
        chk_reset_state("rst");
        chk("rst_abort_pulse", 128'(abort_pulse), 128'(0));
        chk("rst_in0_ready", 128'(in0_ready), 128'(0));

        // Single 4-beat packet on in0, exact cycle timing
        sopq.delete();
        eopq.delete();
        c0 = cyc;
        send(0, 4, 8'hA0);
        drain(100);
        chk("t1_sop_count", 128'(sopq.size()), 128'(1));
        chk("t1_sop_cycle", 128'(sopq[0] - c0), 128'(2));
        chk("t1_eop_cycle", 128'(eopq[0] - c0), 128'(5));
        chk("t1_grant_c1", 128'(glog[c0 + 1]), 128'(2'b01));
        chk("t1_grant_c4", 128'(glog[c0 + 4]), 128'(2'b01));
        chk("t1_grant_c5", 128'(glog[c0 + 5]), 128'(2'b00));
        chk("t1_pkt_cnt0", 128'(pkt_cnt0), 128'(1));

        // Both inputs contending: order 0,1,0,1, one gap cycle between packets
        do_reset();
        sopq.delete();
        eopq.delete();
        send(0, 3, 8'hB0);
        send(1, 3, 8'hC0);
        send(0, 3, 8'hB1);
        send(1, 3, 8'hC1);
        drain(200);
        chk("t2_pkts", 128'(eopq.size()), 128'(4));
        for (int i = 0; i < 4; i++) chk("t2_pkt_len", 128'(eopq[i] - sopq[i]), 128'(2));
        for (int i = 0; i < 3; i++) chk("t2_pkt_gap", 128'(sopq[i + 1] - eopq[i]), 128'(2));
        chk("t2_pkt_cnt0", 128'(pkt_cnt0), 128'(2));
        chk("t2_pkt_cnt1", 128'(pkt_cnt1), 128'(2));

        // Backpressure on a 5-beat in1 packet
        rdy_mode = 1;
        rdy_ph = 0;
        bp_chk = 1'b1;
        hold_viol = 0;
        rdy_viol = 0;
        send(1, 5, 8'hD0);
        drain(200);
        rdy_mode = 0;
        bp_chk = 1'b0;
        chk("t3_hold_viol", 128'(hold_viol), 128'(0));
        chk("t3_ready_viol", 128'(rdy_viol), 128'(0));
        chk("t3_pkt_cnt1", 128'(pkt_cnt1), 128'(3));

        // Stall timeout: SOP + 1 beat, silence, late 2-beat tail
        n_abort = 0;
        abort_gap = -1;
        pc0 = pkt_cnt0;
        send(0, 2, 8'hE0);
        exp_q[1].eop = 1'b0;
        q0[1].eop = 1'b0;
        exp_q.push_back('{'0, 1'b0, 1'b1, 1'b1});
        push_raw(0, 1'b0, 1'b0, 20);
        push_raw(0, 1'b0, 1'b1, 0);
        drain(200);
        chk("t4_abort_pulses", 128'(n_abort), 128'(1));
        chk("t4_abort_gap_ok", 128'(abort_gap >= TIMEOUT && abort_gap <= TIMEOUT + 3), 128'(1));
        chk("t4_pkt_cnt0", 128'(pkt_cnt0), 128'(pc0));
        chk("t4_drop_cnt", 128'(drop_cnt), 128'(2));

        // Orphan saturation and packet counter wrap
        do_reset();
        for (int i = 0; i < 20; i++) push_raw(1, 1'b0, 1'b0, 0);
        drain(100);
        chk("t5_drop_sat", 128'(drop_cnt), 128'(15));
        for (int i = 0; i < 15; i++) send(0, 1, 8'(8'h50 + i));
        drain(200);
        chk("t5_pkt_cnt0_15", 128'(pkt_cnt0), 128'(15));
        send(0, 1, 8'h5F);
        drain(50);
        chk("t5_pkt_cnt0_wrap", 128'(pkt_cnt0), 128'(0));
        chk("t5_drop_hold", 128'(drop_cnt), 128'(15));

        // Reset in the middle of a 6-beat in0 packet
        send(0, 6, 8'hF0);
        c0 = 0;
        while (q0.size() > 4 && c0 < 50) begin
            step();
            c0++;
        end
        chk("t6_reached_beat2", 128'(q0.size()), 128'(4));
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        clear_bench();
        step();
        chk_reset_state("t6");
        c0 = cyc;
        send(0, 2, 8'h60);
        send(1, 2, 8'h70);
        drain(100);
        chk("t6_first_grant", 128'(glog[c0 + 1]), 128'(2'b01));
        chk("t6_pkt_cnt0", 128'(pkt_cnt0), 128'(1));
        chk("t6_pkt_cnt1", 128'(pkt_cnt1), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
